// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the FIFO read-side stream stage: occupancy state encoding.
package fifo_rd_stream_pkg;

  localparam logic [1:0] S_ZERO = 2'd0;
  localparam logic [1:0] S_ONE  = 2'd1;
  localparam logic [1:0] S_TWO  = 2'd2;

endpackage

// File: rtl/fifo_rd_stream.sv
// Drains an async FIFO read port into a registered valid/ready stream via a 2-entry prefetch buffer.
// Optional popped-word counter on POP_CNT when FIFO_RD_STREAM_STATS_EN is defined.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  R_CLK,
  input  logic                  R_RST,
  input  logic                  EMPTY,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  R_INC,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [CNT_WIDTH-1:0]  POP_CNT
);

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  push, pop;

  // Pop request depends only on registered occupancy, so OUT_READY never reaches R_INC.
  assign R_INC     = !EMPTY && (state_q != S_TWO);
  assign push      = R_INC;
  assign OUT_VALID = (state_q != S_ZERO);
  assign pop       = OUT_VALID && OUT_READY;
  assign OUT_DATA  = head_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      S_ZERO: begin
        if (push) begin
          head_d  = RD_DATA;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (push && pop) begin
          head_d = RD_DATA;
        end else if (push) begin
          tail_d  = RD_DATA;
          state_d = S_TWO;
        end else if (pop) begin
          state_d = S_ZERO;
        end
      end
      S_TWO: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_ZERO;
    endcase
  end

  always_ff @(posedge R_CLK or posedge R_RST) begin
    if (R_RST) begin
      state_q <= S_ZERO;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (pop && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge R_CLK or posedge R_RST) begin
    if (R_RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign POP_CNT = cnt_q;
`else
  assign POP_CNT = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a queue-based model of the FIFO and the stream buffer.
module tb_fifo_rd_stream;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;

  logic          R_CLK = 1'b0;
  logic          R_RST;
  logic          EMPTY;
  logic [DW-1:0] RD_DATA;
  logic          R_INC;
  logic [DW-1:0] OUT_DATA;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [CW-1:0] POP_CNT;

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .R_CLK    (R_CLK),
    .R_RST    (R_RST),
    .EMPTY    (EMPTY),
    .RD_DATA  (RD_DATA),
    .R_INC    (R_INC),
    .OUT_DATA (OUT_DATA),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .POP_CNT  (POP_CNT)
  );

  always #5 R_CLK = ~R_CLK;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fifo_m[$];   // words still in the upstream FIFO
  logic [DW-1:0] buf_m[$];    // words accepted but not yet delivered
  int            cnt_m;
  int            cyc;
  logic [DW-1:0] got_w[$];
  int            got_c[$];
  logic          last_rinc, last_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_cnt();
`ifdef FIFO_RD_STREAM_STATS_EN
    return cnt_m;
`else
    return 0;
`endif
  endfunction

  // One clock cycle, entered and left on a falling edge.
  task automatic step(input logic ready, input logic gate_empty);
    logic exp_rinc, do_pop;
    chk("out_valid", OUT_VALID, buf_m.size() != 0);
    if (buf_m.size() != 0) chk("out_data", OUT_DATA, buf_m[0]);
    chk("pop_cnt", POP_CNT, exp_cnt());
    last_valid = OUT_VALID;
    OUT_READY  = ready;
    EMPTY      = gate_empty || (fifo_m.size() == 0);
    RD_DATA    = (fifo_m.size() != 0) ? fifo_m[0] : 8'hEE;
    #1;
    exp_rinc = !EMPTY && (buf_m.size() < 2);
    chk("r_inc", R_INC, exp_rinc);
    last_rinc = R_INC;
    do_pop = (buf_m.size() != 0) && ready;
    if (do_pop) begin
      got_w.push_back(buf_m.pop_front());
      got_c.push_back(cyc);
      if (cnt_m < 255) cnt_m++;
    end
    if (exp_rinc) buf_m.push_back(fifo_m.pop_front());
    cyc++;
    @(negedge R_CLK);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((fifo_m.size() != 0 || buf_m.size() != 0) && n < budget) begin
      step(1'b1, 1'b0);
      n++;
    end
    if (n >= budget) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    int rinc_cnt, valid_cnt, n, seen;
    logic [3:0] rinc_hist;
    cyc = 0; cnt_m = 0;
    R_RST = 1'b1; EMPTY = 1'b1; OUT_READY = 1'b0; RD_DATA = '0;
    @(negedge R_CLK);
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_data", OUT_DATA, 0);
    chk("rst_cnt", POP_CNT, 0);
    chk("rst_rinc", R_INC, 0);
    R_RST = 1'b0;
    @(negedge R_CLK);

    // Test 1: reset while holding two words
    fifo_m = '{8'hA5, 8'h5A};
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    chk("t1_head", OUT_DATA, 8'hA5);
    chk("t1_valid", OUT_VALID, 1);
    #2 R_RST = 1'b1;
    #1;
    chk("t1_rst_valid", OUT_VALID, 0);
    chk("t1_rst_data", OUT_DATA, 0);
    chk("t1_rst_cnt", POP_CNT, 0);
    buf_m.delete(); fifo_m.delete(); cnt_m = 0;
    @(negedge R_CLK);
    R_RST = 1'b0;
    step(1'b0, 1'b0);
    chk("t1_rinc_empty", last_rinc, 0);
    fifo_m.push_back(8'h77);
    step(1'b0, 1'b0);
    chk("t1_rinc_nonempty", last_rinc, 1);
    drain(10);

    // Test 2: full throughput
    got_w.delete(); got_c.delete();
    for (int i = 1; i <= 8; i++) fifo_m.push_back(i[7:0]);
    rinc_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0);
      if (last_rinc) rinc_cnt++;
    end
    chk("t2_rinc_cnt", rinc_cnt, 8);
    chk("t2_words", got_w.size(), 8);
    for (int i = 0; i < 8 && i < got_w.size(); i++) begin
      chk("t2_word", got_w[i], i + 1);
      if (i > 0) chk("t2_gap", got_c[i] - got_c[i-1], 1);
    end

    // Test 3: backpressure
    got_w.delete(); got_c.delete();
    fifo_m = '{8'h10, 8'h11, 8'h12};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0);
      rinc_hist[i] = last_rinc;
    end
    chk("t3_rinc_hist", rinc_hist, 4'b0011);
    chk("t3_held", OUT_DATA, 8'h10);
    drain(10);
    chk("t3_words", got_w.size(), 3);
    for (int i = 0; i < 3 && i < got_w.size(); i++) begin
      chk("t3_word", got_w[i], 8'h10 + i);
      if (i > 0) chk("t3_gap", (got_c[i] - got_c[i-1]) <= 2, 1);
    end

    // Test 4: single word at the empty boundary
    fifo_m.push_back(8'h3C);
    got_w.delete(); got_c.delete();
    rinc_cnt = 0; valid_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0);
      if (last_rinc) rinc_cnt++;
      if (last_valid) valid_cnt++;
    end
    chk("t4_rinc_pulses", rinc_cnt, 1);
    chk("t4_valid_cycles", valid_cnt, 1);
    chk("t4_word", (got_w.size() == 1) ? got_w[0] : 8'h00, 8'h3C);

    // Test 5: random ready with EMPTY toggling
    got_w.delete(); got_c.delete();
    for (int i = 0; i < 256; i++) fifo_m.push_back(8'(i * 37 + 5));
    n = 0;
    while ((fifo_m.size() != 0 || buf_m.size() != 0) && n < 4000) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3));
      if (last_rinc && EMPTY) chk("t5_rinc_when_empty", 1, 0);
      n++;
    end
    if (n >= 4000) chk("t5_timeout", 1, 0);
    chk("t5_words", got_w.size(), 256);
    seen = 0;
    for (int i = 0; i < got_w.size() && i < 256; i++)
      if (got_w[i] === 8'(i * 37 + 5)) seen++;
    chk("t5_order", seen, 256);

    // Test 6: counter saturation
    for (int i = 0; i < 300; i++) fifo_m.push_back(8'(i));
    drain(400);
    step(1'b1, 1'b0);
`ifdef FIFO_RD_STREAM_STATS_EN
    chk("t6_cnt_sat", POP_CNT, 8'hFF);
`else
    chk("t6_cnt_zero", POP_CNT, 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
